// File: rtl/vpp_meas.sv
`timescale 1ns/1ps
// vpp_meas: peak-to-peak measurement for the scope capture path.
// Tracks the running max/min over each data_en frame and averages the
// peak-to-peak value over 2^AVG_LOG2 frames. The average is scaled to display
// units, clamped to the BCD range, and converted to packed BCD by a
// sequential shift-add-3 engine.
module vpp_meas #(
    parameter int DATA_W      = 8,
    parameter int AVG_LOG2    = 2,
    parameter int SCALE_NUM   = 13,
    parameter int SCALE_SHIFT = 5,
    parameter int BCD_DIGITS  = 3
) (
    input  logic                    clk_result,
    input  logic                    rst_n_result,
    input  logic [DATA_W-1:0]       ram_data,
    input  logic                    data_en,
    output logic [DATA_W-1:0]       max_out,
    output logic [DATA_W-1:0]       min_out,
    output logic                    frame_done,
    output logic [4*BCD_DIGITS-1:0] vpp_bcd,
    output logic                    vpp_valid,
    output logic                    vpp_busy,
    output logic                    vpp_ovf,
    output logic                    lost
);

    localparam int BIN_W   = 4 * BCD_DIGITS;
    localparam int ACC_W   = DATA_W + AVG_LOG2;
    localparam int CNT_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int SN_W    = (SCALE_NUM > 1) ? $clog2(SCALE_NUM + 1) : 1;
    localparam int PROD_W  = DATA_W + SN_W;
    localparam int MAX_BCD = (10 ** BCD_DIGITS) - 1;
    localparam int SC_W    = $clog2(BIN_W);
    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Add 3 to every BCD digit that is 5 or more (one double-dabble step).
    function automatic logic [BIN_W-1:0] add3_digits(input logic [BIN_W-1:0] d);
        logic [BIN_W-1:0] r;
        r = d;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (d[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = d[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = d[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Frame tracking state
    logic [DATA_W-1:0] run_max_r;
    logic [DATA_W-1:0] run_min_r;
    logic              seen_r;
    logic              en_d_r;
    logic              close_s;
    logic [DATA_W-1:0] pp_s;

    // Averaging state
    logic [ACC_W-1:0]  acc_r;
    logic [CNT_W-1:0]  frm_cnt_r;
    logic [ACC_W-1:0]  acc_sum_s;
    logic [DATA_W-1:0] avg_s;
    logic              avg_ready_s;

    // Scaling
    logic [PROD_W-1:0] prod_s;
    logic [PROD_W-1:0] shifted_s;
    logic [BIN_W-1:0]  scaled_s;
    logic              sat_s;
    logic [BIN_W-1:0]  s_r;
    logic              s_ovf_r;
    logic              s_valid_r;
    logic              accept_s;

    // Converter
    state_t            state_r;
    state_t            state_next_s;
    logic              load_s;
    logic              shift_s;
    logic              done_s;
    logic [BIN_W-1:0]  bcd_r;
    logic [BIN_W-1:0]  bin_r;
    logic [BIN_W-1:0]  bcd_adj_s;
    logic              conv_ovf_r;
    logic [SC_W-1:0]   shift_cnt_r;

    // A frame closes on the first idle edge after at least one sample.
    always_comb begin
        close_s     = (!data_en) && en_d_r && seen_r;
        pp_s        = run_max_r - run_min_r;
        acc_sum_s   = acc_r + ACC_W'(pp_s);
        avg_s       = DATA_W'(acc_sum_s >> AVG_LOG2);
        avg_ready_s = close_s && (frm_cnt_r == LAST_FRAME);
        // A result is taken only if the converter is idle with nothing pending.
        accept_s    = avg_ready_s && (state_r == ST_IDLE) && (!s_valid_r);
    end

    // Scale the average and saturate to the largest displayable value.
    always_comb begin
        prod_s    = PROD_W'(avg_s) * PROD_W'(SCALE_NUM);
        shifted_s = prod_s >> SCALE_SHIFT;
        if (64'(shifted_s) > 64'(MAX_BCD)) begin
            sat_s    = 1'b1;
            scaled_s = BIN_W'(MAX_BCD);
        end else begin
            sat_s    = 1'b0;
            scaled_s = BIN_W'(shifted_s);
        end
    end

    // Running max/min per frame and the closed-frame result registers.
    always_ff @(posedge clk_result or negedge rst_n_result) begin
        if (!rst_n_result) begin
            run_max_r  <= {DATA_W{1'b0}};
            run_min_r  <= {DATA_W{1'b1}};
            seen_r     <= 1'b0;
            en_d_r     <= 1'b0;
            max_out    <= {DATA_W{1'b0}};
            min_out    <= {DATA_W{1'b0}};
            frame_done <= 1'b0;
        end else begin
            en_d_r     <= data_en;
            frame_done <= close_s;
            if (data_en) begin
                if (ram_data > run_max_r) begin
                    run_max_r <= ram_data;
                end else begin
                    run_max_r <= run_max_r;
                end
                if (ram_data < run_min_r) begin
                    run_min_r <= ram_data;
                end else begin
                    run_min_r <= run_min_r;
                end
                seen_r <= 1'b1;
            end else if (close_s) begin
                max_out   <= run_max_r;
                min_out   <= run_min_r;
                run_max_r <= {DATA_W{1'b0}};
                run_min_r <= {DATA_W{1'b1}};
                seen_r    <= 1'b0;
            end else begin
                seen_r <= seen_r;
            end
        end
    end

    // Accumulate peak-to-peak values; clear on the last frame of a group.
    always_ff @(posedge clk_result or negedge rst_n_result) begin
        if (!rst_n_result) begin
            acc_r     <= {ACC_W{1'b0}};
            frm_cnt_r <= {CNT_W{1'b0}};
        end else if (close_s) begin
            if (frm_cnt_r == LAST_FRAME) begin
                acc_r     <= {ACC_W{1'b0}};
                frm_cnt_r <= {CNT_W{1'b0}};
            end else begin
                acc_r     <= acc_sum_s;
                frm_cnt_r <= frm_cnt_r + CNT_W'(1);
            end
        end else begin
            acc_r <= acc_r;
        end
    end

    // Capture a scaled result for the converter, or flag it lost when busy.
    always_ff @(posedge clk_result or negedge rst_n_result) begin
        if (!rst_n_result) begin
            s_r       <= {BIN_W{1'b0}};
            s_ovf_r   <= 1'b0;
            s_valid_r <= 1'b0;
            lost      <= 1'b0;
        end else begin
            lost <= avg_ready_s && (!accept_s);
            if (accept_s) begin
                s_r       <= scaled_s;
                s_ovf_r   <= sat_s;
                s_valid_r <= 1'b1;
            end else if (state_r == ST_IDLE) begin
                s_valid_r <= 1'b0;
            end else begin
                s_valid_r <= s_valid_r;
            end
        end
    end

    // Converter state register.
    always_ff @(posedge clk_result or negedge rst_n_result) begin
        if (!rst_n_result) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Converter next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (s_valid_r) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD:  state_next_s = ST_SHIFT;
            ST_SHIFT: begin
                if (shift_cnt_r == SC_W'(BIN_W - 1)) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Converter control decode.
    always_comb begin
        load_s  = 1'b0;
        shift_s = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            ST_LOAD:  load_s  = 1'b1;
            ST_SHIFT: shift_s = 1'b1;
            ST_DONE:  done_s  = 1'b1;
            default: begin
                load_s  = 1'b0;
                shift_s = 1'b0;
                done_s  = 1'b0;
            end
        endcase
    end

    // Digit correction applied before each left shift.
    always_comb begin
        bcd_adj_s = add3_digits(bcd_r);
    end

    // Shift-add-3 datapath: BCD and binary registers shift as one word.
    always_ff @(posedge clk_result or negedge rst_n_result) begin
        if (!rst_n_result) begin
            bcd_r       <= {BIN_W{1'b0}};
            bin_r       <= {BIN_W{1'b0}};
            conv_ovf_r  <= 1'b0;
            shift_cnt_r <= {SC_W{1'b0}};
        end else if (load_s) begin
            bcd_r       <= {BIN_W{1'b0}};
            bin_r       <= s_r;
            conv_ovf_r  <= s_ovf_r;
            shift_cnt_r <= {SC_W{1'b0}};
        end else if (shift_s) begin
            {bcd_r, bin_r} <= {bcd_adj_s[BIN_W-2:0], bin_r[BIN_W-1], bin_r[BIN_W-2:0], 1'b0};
            shift_cnt_r    <= shift_cnt_r + SC_W'(1);
        end else begin
            shift_cnt_r <= shift_cnt_r;
        end
    end

    // Registered result outputs and busy flag.
    always_ff @(posedge clk_result or negedge rst_n_result) begin
        if (!rst_n_result) begin
            vpp_bcd   <= {BIN_W{1'b0}};
            vpp_ovf   <= 1'b0;
            vpp_valid <= 1'b0;
            vpp_busy  <= 1'b0;
        end else begin
            vpp_busy  <= (state_next_s != ST_IDLE);
            vpp_valid <= done_s;
            if (done_s) begin
                vpp_bcd <= bcd_r;
                vpp_ovf <= conv_ovf_r;
            end else begin
                vpp_bcd <= vpp_bcd;
            end
        end
    end

endmodule

// File: tb/tb_vpp_meas.sv
`timescale 1ns/1ps
// Bench for vpp_meas: three configurations share one stimulus stream and are
// each compared every cycle against a frame-level reference model.
module tb_vpp_meas;

    localparam int NI = 3;
    // Instance 0: defaults; 1: no averaging; 2: no averaging, gain 255/1.
    localparam int A_P [NI]  = '{2, 0, 0};
    localparam int SN_P [NI] = '{13, 13, 255};
    localparam int SS_P [NI] = '{5, 5, 0};

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] ram_data;
    logic data_en;

    logic [NI-1:0][7:0]  max_o;
    logic [NI-1:0][7:0]  min_o;
    logic [NI-1:0]       fd_o;
    logic [NI-1:0][11:0] bcd_o;
    logic [NI-1:0]       val_o;
    logic [NI-1:0]       busy_o;
    logic [NI-1:0]       ovf_o;
    logic [NI-1:0]       lost_o;

    always #5 clk = ~clk;

    vpp_meas #(.DATA_W(8), .AVG_LOG2(2), .SCALE_NUM(13), .SCALE_SHIFT(5), .BCD_DIGITS(3)) u_def (
        .clk_result(clk), .rst_n_result(rst_n), .ram_data(ram_data), .data_en(data_en),
        .max_out(max_o[0]), .min_out(min_o[0]), .frame_done(fd_o[0]), .vpp_bcd(bcd_o[0]),
        .vpp_valid(val_o[0]), .vpp_busy(busy_o[0]), .vpp_ovf(ovf_o[0]), .lost(lost_o[0]));

    vpp_meas #(.DATA_W(8), .AVG_LOG2(0), .SCALE_NUM(13), .SCALE_SHIFT(5), .BCD_DIGITS(3)) u_noavg (
        .clk_result(clk), .rst_n_result(rst_n), .ram_data(ram_data), .data_en(data_en),
        .max_out(max_o[1]), .min_out(min_o[1]), .frame_done(fd_o[1]), .vpp_bcd(bcd_o[1]),
        .vpp_valid(val_o[1]), .vpp_busy(busy_o[1]), .vpp_ovf(ovf_o[1]), .lost(lost_o[1]));

    vpp_meas #(.DATA_W(8), .AVG_LOG2(0), .SCALE_NUM(255), .SCALE_SHIFT(0), .BCD_DIGITS(3)) u_sat (
        .clk_result(clk), .rst_n_result(rst_n), .ram_data(ram_data), .data_en(data_en),
        .max_out(max_o[2]), .min_out(min_o[2]), .frame_done(fd_o[2]), .vpp_bcd(bcd_o[2]),
        .vpp_valid(val_o[2]), .vpp_busy(busy_o[2]), .vpp_ovf(ovf_o[2]), .lost(lost_o[2]));

    int n_checks = 0;
    int n_fail   = 0;
    longint cyc  = 0;

    // Reference model state
    int     frame_q[$];
    int     exp_max, exp_min;
    bit     exp_fd;
    int     grp_sum [NI];
    int     grp_cnt [NI];
    longint accept_cyc [NI];
    longint valid_cyc [NI];
    int     pend_bcd [NI];
    int     pend_ovf [NI];
    int     held_bcd [NI];
    int     held_ovf [NI];
    bit     exp_lost [NI];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic int to_bcd(input int v);
        int r = 0;
        int x = v;
        for (int i = 0; i < 3; i++) begin
            r = r | ((x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        frame_q.delete();
        exp_max = 0;
        exp_min = 0;
        exp_fd  = 1'b0;
        for (int k = 0; k < NI; k++) begin
            grp_sum[k]    = 0;
            grp_cnt[k]    = 0;
            accept_cyc[k] = -1000;
            valid_cyc[k]  = -1;
            pend_bcd[k]   = 0;
            pend_ovf[k]   = 0;
            held_bcd[k]   = 0;
            held_ovf[k]   = 0;
            exp_lost[k]   = 1'b0;
        end
    endtask

    // Frame close: max/min, peak-to-peak, group average, scale, deliver/drop.
    task automatic model_close();
        int mx = 0;
        int mn = 255;
        int pp, avg, s;
        foreach (frame_q[i]) begin
            if (frame_q[i] > mx) mx = frame_q[i];
            if (frame_q[i] < mn) mn = frame_q[i];
        end
        frame_q.delete();
        pp = mx - mn;
        exp_max = mx;
        exp_min = mn;
        exp_fd  = 1'b1;
        for (int k = 0; k < NI; k++) begin
            grp_sum[k] += pp;
            grp_cnt[k] += 1;
            if (grp_cnt[k] == (1 << A_P[k])) begin
                avg = grp_sum[k] >> A_P[k];
                s   = (avg * SN_P[k]) >> SS_P[k];
                grp_sum[k] = 0;
                grp_cnt[k] = 0;
                if (cyc - accept_cyc[k] >= 16) begin
                    accept_cyc[k] = cyc;
                    valid_cyc[k]  = cyc + 15;
                    pend_ovf[k]   = (s > 999) ? 1 : 0;
                    pend_bcd[k]   = to_bcd((s > 999) ? 999 : s);
                end else begin
                    exp_lost[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_edge();
        cyc++;
        exp_fd = 1'b0;
        for (int k = 0; k < NI; k++) exp_lost[k] = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (data_en) begin
            frame_q.push_back(int'(ram_data));
        end else if (frame_q.size() > 0) begin
            model_close();
        end
    endtask

    task automatic check_all();
        bit ev;
        bit eb;
        for (int k = 0; k < NI; k++) begin
            ev = (cyc == valid_cyc[k]);
            if (ev) begin
                held_bcd[k] = pend_bcd[k];
                held_ovf[k] = pend_ovf[k];
            end
            eb = (cyc > accept_cyc[k]) && (cyc <= accept_cyc[k] + 14);
            check_eq($sformatf("max_out[%0d]", k),    max_o[k],  exp_max);
            check_eq($sformatf("min_out[%0d]", k),    min_o[k],  exp_min);
            check_eq($sformatf("frame_done[%0d]", k), fd_o[k],   exp_fd);
            check_eq($sformatf("vpp_valid[%0d]", k),  val_o[k],  ev);
            check_eq($sformatf("vpp_bcd[%0d]", k),    bcd_o[k],  held_bcd[k]);
            check_eq($sformatf("vpp_ovf[%0d]", k),    ovf_o[k],  held_ovf[k]);
            check_eq($sformatf("vpp_busy[%0d]", k),   busy_o[k], eb);
            check_eq($sformatf("lost[%0d]", k),       lost_o[k], exp_lost[k]);
        end
    endtask

    task automatic tick(input bit en, input int d);
        data_en  = en;
        ram_data = 8'(d);
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic apply_reset(input int hold);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        for (int i = 0; i < hold; i++) tick(1'b0, 0);
        rst_n = 1'b1;
    endtask

    task automatic frame(input int a, input int b, input int c, input int n, input int gap);
        int smp [3];
        smp[0] = a;
        smp[1] = b;
        smp[2] = c;
        for (int i = 0; i < n; i++) tick(1'b1, smp[i]);
        for (int i = 0; i < gap; i++) tick(1'b0, 0);
    endtask

    initial begin
        rst_n    = 1'b1;
        data_en  = 1'b0;
        ram_data = 8'd0;
        model_reset();
        #2;
        apply_reset(3);

        // Basic frame: max 200, min 10, pp 190.
        frame(10, 200, 50, 3, 20);

        // Four-frame group with pp 100,100,200,200.
        apply_reset(2);
        frame(0, 100, 0, 2, 20);
        frame(50, 150, 0, 2, 20);
        frame(0, 200, 0, 2, 20);
        frame(55, 255, 0, 2, 20);

        // Saturation frame 0/255, then a single-sample frame and idle period.
        apply_reset(2);
        frame(0, 255, 0, 2, 20);
        frame(77, 0, 0, 1, 30);

        // Second frame closes 5 cycles after the first.
        apply_reset(2);
        frame(10, 110, 0, 2, 1);
        tick(1'b1, 40);
        tick(1'b1, 90);
        tick(1'b1, 60);
        tick(1'b1, 45);
        for (int i = 0; i < 30; i++) tick(1'b0, 0);

        // Reset during conversion, then reset mid-frame.
        apply_reset(2);
        frame(20, 220, 0, 2, 6);
        apply_reset(2);
        tick(1'b1, 5);
        tick(1'b1, 250);
        apply_reset(2);
        frame(30, 130, 0, 2, 20);

        // Randomized frames with random lengths and idle gaps.
        apply_reset(2);
        for (int f = 0; f < 80; f++) begin
            int len;
            int gap;
            len = int'($urandom_range(1, 5));
            gap = int'($urandom_range(1, 20));
            for (int i = 0; i < len; i++) tick(1'b1, int'($urandom_range(0, 255)));
            for (int i = 0; i < gap; i++) tick(1'b0, 0);
        end
        for (int i = 0; i < 20; i++) tick(1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
